// File: rtl/npu_pkg.sv
// Shared definitions for the NPU memory-mapped port: addresses, control-word
// bits, the image feeder state enum and the bus command record.
package npu_pkg;

  localparam logic [15:0] NPU_ADDR_IMG  = 16'h1000;
  localparam logic [15:0] NPU_ADDR_CTRL = 16'h4000;

  typedef enum int {
    CTRL_TRIGGER_BIT  = 0,
    CTRL_NEXT_BIT     = 1,
    CTRL_PE_CLR_BIT   = 2,
    CTRL_IMG_CLR_BIT  = 3,
    CTRL_W_CLR_BIT    = 4,
    CTRL_PACK_CLR_BIT = 5
  } ctrl_bit_e;

  localparam logic [31:0] CTRL_REL  = 32'h0;
  localparam logic [31:0] CTRL_TRIG = 32'(1) << CTRL_TRIGGER_BIT;
  localparam logic [31:0] CTRL_CLR  = (32'(1) << CTRL_PE_CLR_BIT)
                                    | (32'(1) << CTRL_IMG_CLR_BIT)
                                    | (32'(1) << CTRL_PACK_CLR_BIT);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_CLR_REL, S_FILL, S_IMG, S_TRIG, S_REL, S_GAP, S_DONE
  } feeder_state_e;

  typedef struct packed {
    logic        ena;
    logic [15:0] addr;
    logic [31:0] dina;
  } npu_cmd_t;

endpackage

// File: rtl/npu_img_feeder_line_buf.sv
// Column-indexed line buffers: entry 0 holds the oldest row. Reads at idx are
// combinational and see the contents before a same-cycle shift at idx.
module line_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 15,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      idx,
  input  logic [7:0]            din,
  output logic [DEPTH-1:0][7:0] rd_data
);

  logic [7:0] mem_q [DEPTH][WIDTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) rd_data[i] = mem_q[i][idx];
  end

  // NOTE: pixel storage has no reset; every entry is written by the first
  // rows of a frame before it is ever read, so a reset would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i][idx] <= mem_q[i+1][idx];
      mem_q[DEPTH-1][idx] <= din;
    end
  end

endmodule

// File: rtl/npu_img_feeder.sv
// Streams raster pixels into the NPU image port: buffers K_H-1 rows, then
// writes one vertical column per pixel followed by a trigger/release pair.
module npu_img_feeder
  import npu_pkg::*;
#(
  parameter int K_H     = 3,
  parameter int IN_H    = 16,
  parameter int IN_W    = 15,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_ena,
  output logic        m_wea,
  output logic [15:0] m_addra,
  output logic [31:0] m_dina,
  output logic        busy,
  output logic        frame_done
);

  localparam int LB_ROWS = K_H - 1;
  localparam int ROW_W   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int COL_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  feeder_state_e          state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   last_q, last_d;
  logic [31:0]            triple_q, triple_d;
  npu_cmd_t               cmd_q, cmd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [LB_ROWS-1:0][7:0] lb_rd;
  logic                   at_row_end, at_last_row;

  assign s_ready     = (state_q == S_FILL);
  assign at_row_end  = (col_q == COL_W'(IN_W - 1));
  assign at_last_row = (row_q == ROW_W'(IN_H - 1));

  line_buf #(.DEPTH(LB_ROWS), .WIDTH(IN_W), .IDX_W(COL_W)) u_line_buf (
    .clk     (clk),
    .wr_en   (s_valid && s_ready),
    .idx     (col_q),
    .din     (s_data),
    .rd_data (lb_rd)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    gap_d    = gap_q;
    last_d   = last_q;
    triple_d = triple_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CLR;
        row_d   = '0;
        col_d   = '0;
      end
      S_CLR:     state_d = S_CLR_REL;
      S_CLR_REL: state_d = S_FILL;
      S_FILL: if (s_valid) begin
        last_d = at_row_end && at_last_row;
        if (!at_row_end) begin
          col_d = col_q + 1'b1;
        end else if (!at_last_row) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end
        if (row_q >= ROW_W'(LB_ROWS)) begin
          triple_d = '0;
          for (int i = 0; i < LB_ROWS; i++) triple_d[8*i +: 8] = lb_rd[i];
          triple_d[8*LB_ROWS +: 8] = s_data;
          state_d = S_IMG;
        end
      end
      S_IMG:  state_d = S_TRIG;
      S_TRIG: state_d = S_REL;
      S_REL: begin
        state_d = S_GAP;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = last_q ? S_DONE : S_FILL;
        else                              gap_d   = gap_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus command reflects the state the FSM was in during the previous cycle.
  always_comb begin
    cmd_d  = '0;
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
    unique case (state_q)
      S_CLR:            cmd_d = '{ena: 1'b1, addr: NPU_ADDR_CTRL, dina: CTRL_CLR};
      S_CLR_REL, S_REL: cmd_d = '{ena: 1'b1, addr: NPU_ADDR_CTRL, dina: CTRL_REL};
      S_IMG:            cmd_d = '{ena: 1'b1, addr: NPU_ADDR_IMG,  dina: triple_q};
      S_TRIG:           cmd_d = '{ena: 1'b1, addr: NPU_ADDR_CTRL, dina: CTRL_TRIG};
      default:          cmd_d = '0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignment so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      gap_q    <= '0;
      last_q   <= 1'b0;
      triple_q <= '0;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      triple_q <= triple_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign m_ena      = cmd_q.ena;
  assign m_wea      = cmd_q.ena;
  assign m_addra    = cmd_q.addr;
  assign m_dina     = cmd_q.dina;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_npu_img_feeder.sv
// Self-checking bench for npu_img_feeder: frames of raster or random pixels are
// compared write-by-write against a column-triple model built from the image.
module tb_npu_img_feeder;

  localparam int K_H     = 3;
  localparam int IN_H    = 16;
  localparam int IN_W    = 15;
  localparam int GAP_CYC = 2;
  localparam int N_PIX   = IN_H * IN_W;
  localparam int N_COLS  = (IN_H - K_H + 1) * IN_W;

  logic        clk = 1'b0, rst_ni = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, m_ena, m_wea, busy, frame_done;
  logic [15:0] m_addra;
  logic [31:0] m_dina;

  always #5 clk = ~clk;

  npu_img_feeder #(.K_H(K_H), .IN_H(IN_H), .IN_W(IN_W), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_ena(m_ena), .m_wea(m_wea), .m_addra(m_addra), .m_dina(m_dina),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
  wr_t        got_q[$], exp_q[$];
  logic [7:0] img [IN_H][IN_W];
  int n_checks = 0, n_fail = 0;
  int wea_err, idle_err, timing_err, done_cnt, to_err, first_bad;
  int cyc = 0, last_rel = -1000;
  bit mon_en = 1'b0, prev_ready = 1'b0, prev_trig = 1'b0;
  time t_start, t_done;
  int golden_cycles = -1;

  // Bus monitor: records every write and flags protocol-level violations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_wea !== m_ena) wea_err++;
      if (prev_ready && m_ena === 1'b1) idle_err++;
      if (m_ena === 1'b1) begin
        got_q.push_back({m_addra, m_dina});
        if (m_addra == 16'h4000 && m_dina == 32'h1 && prev_trig) timing_err++;
        if (m_addra == 16'h1000 && cyc - last_rel < GAP_CYC + 1) timing_err++;
        if (m_addra == 16'h4000 && m_dina == 32'h0) last_rel = cyc;
      end
      prev_trig = (m_ena === 1'b1) && m_addra == 16'h4000 && m_dina == 32'h1;
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) t_done = $time;
      end
    end
    prev_ready = (s_ready === 1'b1);
    cyc++;
  end

  // Reference: prologue, then per pixel of rows K_H-1.. one column + trig + rel.
  function automatic void build_expected();
    exp_q.delete();
    exp_q.push_back({16'h4000, 32'h2C});
    exp_q.push_back({16'h4000, 32'h00});
    for (int r = K_H - 1; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++) begin
        logic [31:0] d = '0;
        for (int k = 0; k < K_H; k++) d[8*k +: 8] = img[r-(K_H-1)+k][c];
        exp_q.push_back({16'h1000, d});
        exp_q.push_back({16'h4000, 32'h01});
        exp_q.push_back({16'h4000, 32'h00});
      end
  endfunction

  function automatic int stream_diffs();
    int n = 0;
    first_bad = -1;
    if (got_q.size() != exp_q.size()) n++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        n++;
        if (first_bad < 0) first_bad = i;
      end
    return n;
  endfunction

  function automatic int count_writes(input logic [15:0] a, input logic [31:0] d, input bit any_d);
    int n = 0;
    foreach (got_q[i]) if (got_q[i].a == a && (any_d || got_q[i].d == d)) n++;
    return n;
  endfunction

  task automatic run_frame(input bit rnd_px, input bit rnd_stall, input int fill_stall_idx,
                           input bit spam_start, input int abort_idx, output bit aborted);
    aborted = 1'b0;
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        img[r][c] = rnd_px ? 8'($urandom) : 8'(r * IN_W + c);
    build_expected();
    got_q.delete();
    wea_err = 0; idle_err = 0; timing_err = 0; done_cnt = 0; to_err = 0; last_rel = -1000;
    mon_en = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_data = img[0][0]; start = 1'b1; t_start = $time;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 0; idx < N_PIX; idx++) begin
      int n = 0;
      if (rnd_stall && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      if (idx == fill_stall_idx) begin
        s_valid = 1'b0;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        n = 0;
      end
      if (spam_start) start = (idx % 7 == 3);
      s_valid = 1'b1;
      s_data  = img[idx / IN_W][idx % IN_W];
      while (!s_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) to_err++;
      @(negedge clk);
      start = 1'b0;
      if (idx == abort_idx) begin
        n = 0;
        s_valid = 1'b0;
        while (!(m_ena === 1'b1 && m_addra == 16'h1000) && n < 20) begin @(negedge clk); n++; end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++; if (m_ena !== 1'b0)      begin n_fail++; $display("FAIL abort_m_ena got=%b exp=0", m_ena); end
        n_checks++; if (m_wea !== 1'b0)      begin n_fail++; $display("FAIL abort_m_wea got=%b exp=0", m_wea); end
        n_checks++; if (m_addra !== 16'h0)   begin n_fail++; $display("FAIL abort_m_addra got=%h exp=0", m_addra); end
        n_checks++; if (m_dina !== 32'h0)    begin n_fail++; $display("FAIL abort_m_dina got=%h exp=0", m_dina); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_checks++; if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL abort_s_ready got=%b exp=0", s_ready); end
        n_checks++; if (n >= 20)             begin n_fail++; $display("FAIL abort_wait_img got=timeout exp=img_write"); end
        @(negedge clk);
        rst_ni = 1'b1;
        mon_en = 1'b0;
        aborted = 1'b1;
        return;
      end
    end
    s_valid = 1'b0;
    for (int n = 0; n < 100 && done_cnt == 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    n_checks++; if (m_ena !== 1'b0)      begin n_fail++; $display("FAIL rst_m_ena got=%b exp=0", m_ena); end
    n_checks++; if (m_wea !== 1'b0)      begin n_fail++; $display("FAIL rst_m_wea got=%b exp=0", m_wea); end
    n_checks++; if (m_addra !== 16'h0)   begin n_fail++; $display("FAIL rst_m_addra got=%h exp=0", m_addra); end
    n_checks++; if (m_dina !== 32'h0)    begin n_fail++; $display("FAIL rst_m_dina got=%h exp=0", m_dina); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    n_checks++; if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || m_ena !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_rst busy=%b m_ena=%b exp=0/0", busy, m_ena); end
  endtask

  task automatic test_prologue();
    s_valid = 1'b1; s_data = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pro_busy got=%b exp=1", busy); end
    n_checks++; if ({m_ena, m_wea, m_addra, m_dina} !== {2'b11, 16'h4000, 32'h2C})
      begin n_fail++; $display("FAIL pro_clr got=%b%b/%h/%h exp=11/4000/0000002c", m_ena, m_wea, m_addra, m_dina); end
    @(negedge clk);
    n_checks++; if ({m_ena, m_wea, m_addra, m_dina} !== {2'b11, 16'h4000, 32'h00})
      begin n_fail++; $display("FAIL pro_rel got=%b%b/%h/%h exp=11/4000/00000000", m_ena, m_wea, m_addra, m_dina); end
    s_valid = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raster_frame();
    bit ab;
    int cycles;
    run_frame(1'b0, 1'b0, -1, 1'b0, -1, ab);
    cycles = int'((t_done - t_start) / 10);
    golden_cycles = cycles;
    n_checks++; if (got_q.size() < 6 || got_q[2] !== {16'h1000, 32'h001E0F00})
      begin n_fail++; $display("FAIL first_img got=%h exp=1000_001e0f00", got_q.size() > 2 ? got_q[2] : '0); end
    n_checks++; if (got_q.size() < 6 || got_q[5] !== {16'h1000, 32'h001F1001})
      begin n_fail++; $display("FAIL second_img got=%h exp=1000_001f1001", got_q.size() > 5 ? got_q[5] : '0); end
    n_checks++; if (stream_diffs() != 0)
      begin n_fail++; $display("FAIL raster_stream writes=%0d exp=%0d first_bad=%0d", got_q.size(), exp_q.size(), first_bad); end
    n_checks++; if (count_writes(16'h1000, 32'h0, 1'b1) != N_COLS)
      begin n_fail++; $display("FAIL img_count got=%0d exp=%0d", count_writes(16'h1000, 32'h0, 1'b1), N_COLS); end
    n_checks++; if (count_writes(16'h4000, 32'h1, 1'b0) != N_COLS)
      begin n_fail++; $display("FAIL trig_count got=%0d exp=%0d", count_writes(16'h4000, 32'h1, 1'b0), N_COLS); end
    n_checks++; if (count_writes(16'h4000, 32'h0, 1'b0) != N_COLS + 1)
      begin n_fail++; $display("FAIL rel_count got=%0d exp=%0d", count_writes(16'h4000, 32'h0, 1'b0), N_COLS + 1); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL raster_done got=%0d exp=1", done_cnt); end
    n_checks++; if (cycles < 2 + 30 + N_COLS * (4 + GAP_CYC) || cycles > 2 + 30 + N_COLS * (4 + GAP_CYC) + 4)
      begin n_fail++; $display("FAIL frame_cycles got=%0d exp=%0d..%0d", cycles, 2 + 30 + N_COLS * (4 + GAP_CYC), 2 + 30 + N_COLS * (4 + GAP_CYC) + 4); end
    n_checks++; if (wea_err != 0 || idle_err != 0 || timing_err != 0 || to_err != 0)
      begin n_fail++; $display("FAIL raster_protocol wea=%0d idle=%0d timing=%0d timeout=%0d exp=0", wea_err, idle_err, timing_err, to_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL raster_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_random_stalls();
    bit ab;
    for (int f = 0; f < 2; f++) begin
      run_frame(1'b1, 1'b1, -1, 1'b0, -1, ab);
      n_checks++; if (stream_diffs() != 0)
        begin n_fail++; $display("FAIL rand_stream frame=%0d writes=%0d exp=%0d first_bad=%0d", f, got_q.size(), exp_q.size(), first_bad); end
      n_checks++; if (done_cnt != 1 || wea_err != 0 || idle_err != 0 || timing_err != 0 || to_err != 0)
        begin n_fail++; $display("FAIL rand_protocol frame=%0d done=%0d wea=%0d idle=%0d timing=%0d timeout=%0d exp=1/0/0/0/0", f, done_cnt, wea_err, idle_err, timing_err, to_err); end
    end
  endtask

  task automatic test_fill_stall();
    bit ab;
    run_frame(1'b1, 1'b0, 5 * IN_W + 7, 1'b0, -1, ab);
    n_checks++; if (stream_diffs() != 0)
      begin n_fail++; $display("FAIL stall_stream writes=%0d exp=%0d first_bad=%0d", got_q.size(), exp_q.size(), first_bad); end
    n_checks++; if (idle_err != 0 || done_cnt != 1 || to_err != 0)
      begin n_fail++; $display("FAIL stall_idle_bus idle=%0d done=%0d timeout=%0d exp=0/1/0", idle_err, done_cnt, to_err); end
  endtask

  task automatic test_start_while_busy();
    bit ab;
    int cycles;
    run_frame(1'b1, 1'b0, -1, 1'b1, -1, ab);
    cycles = int'((t_done - t_start) / 10);
    n_checks++; if (stream_diffs() != 0)
      begin n_fail++; $display("FAIL spam_stream writes=%0d exp=%0d first_bad=%0d", got_q.size(), exp_q.size(), first_bad); end
    n_checks++; if (count_writes(16'h4000, 32'h2C, 1'b0) != 1)
      begin n_fail++; $display("FAIL spam_clr_count got=%0d exp=1", count_writes(16'h4000, 32'h2C, 1'b0)); end
    n_checks++; if (cycles != golden_cycles || done_cnt != 1)
      begin n_fail++; $display("FAIL spam_timing cycles=%0d done=%0d exp=%0d/1", cycles, done_cnt, golden_cycles); end
  endtask

  task automatic test_reset_mid_frame();
    bit ab;
    run_frame(1'b0, 1'b0, -1, 1'b0, 7 * IN_W + 3, ab);
    n_checks++; if (!ab || done_cnt != 0)
      begin n_fail++; $display("FAIL abort_flow aborted=%0b done=%0d exp=1/0", ab, done_cnt); end
    repeat (2) @(negedge clk);
    run_frame(1'b0, 1'b0, -1, 1'b0, -1, ab);
    n_checks++; if (stream_diffs() != 0)
      begin n_fail++; $display("FAIL post_abort_stream writes=%0d exp=%0d first_bad=%0d", got_q.size(), exp_q.size(), first_bad); end
    n_checks++; if (done_cnt != 1 || int'((t_done - t_start) / 10) != golden_cycles)
      begin n_fail++; $display("FAIL post_abort_timing done=%0d cycles=%0d exp=1/%0d", done_cnt, int'((t_done - t_start) / 10), golden_cycles); end
  endtask

  initial begin
    test_reset();
    test_prologue();
    test_raster_frame();
    test_random_stalls();
    test_fill_stall();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
